// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and data ports,
// data-first with starvation boost for fetch, responses routed by a tag pipeline.
module mem_port_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          fetch_boost
);
    typedef struct packed {
        logic v;
        logic o;
        logic w;
    } tag_t;

    tag_t [MEM_LAT-1:0] r_tag;
    logic [3:0]         r_wait_cnt;
    tag_t               w_last;

    assign fetch_boost = r_wait_cnt == 4'(MAX_WAIT);
    // Grants are gated by RSTn so nothing reaches the RAM while in reset.
    assign i_gnt = RSTn & i_req & (~d_req | fetch_boost);
    assign d_gnt = RSTn & d_req & ~(i_req & fetch_boost);

    assign mem_en    = i_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = i_gnt ? i_addr : d_gnt ? d_addr : '0;
    assign mem_wdata = d_gnt ? d_wdata : '0;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wait_cnt <= '0;
            r_tag      <= '0;
        end else begin
            r_wait_cnt <= (i_req & ~i_gnt) ? (fetch_boost ? r_wait_cnt : r_wait_cnt + 4'd1) : 4'd0;
            r_tag[0]   <= {mem_en, d_gnt, mem_we};
            for (int k = 1; k < MEM_LAT; k++)
                r_tag[k] <= r_tag[k-1];
        end
    end

    assign w_last   = r_tag[MEM_LAT-1];
    assign i_rvalid = w_last.v & ~w_last.o;
    assign d_rvalid = w_last.v & w_last.o;
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = (d_rvalid & ~w_last.w) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter at MEM_LAT 1, 3 and 2.
module tb_mem_port_arbiter;
    logic        CLK = 0;
    logic        RSTn = 0;
    logic        i_req = 0, d_req = 0, d_we = 0;
    logic [9:0]  i_addr = 0, d_addr = 0;
    logic [31:0] d_wdata = 0;
    logic [31:0] mem_rdata_a = 0, mem_rdata_b, mem_rdata_c = 0;
    int          n_chk = 0, n_err = 0;

    logic        i_gnt_a, i_rvalid_a, d_gnt_a, d_rvalid_a, mem_en_a, mem_we_a, boost_a;
    logic [31:0] i_rdata_a, d_rdata_a, mem_wdata_a;
    logic [9:0]  mem_addr_a;
    logic        i_gnt_b, i_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b, mem_we_b, boost_b;
    logic [31:0] i_rdata_b, d_rdata_b, mem_wdata_b;
    logic [9:0]  mem_addr_b;
    logic        i_gnt_c, i_rvalid_c, d_gnt_c, d_rvalid_c, mem_en_c, mem_we_c, boost_c;
    logic [31:0] i_rdata_c, d_rdata_c, mem_wdata_c;
    logic [9:0]  mem_addr_c;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.MEM_LAT(1)) u_a (
        .CLK(CLK), .RSTn(RSTn), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_a),
        .i_rvalid(i_rvalid_a), .i_rdata(i_rdata_a), .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a),
        .d_rdata(d_rdata_a), .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .fetch_boost(boost_a));

    mem_port_arbiter #(.MEM_LAT(3)) u_b (
        .CLK(CLK), .RSTn(RSTn), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_b),
        .i_rvalid(i_rvalid_b), .i_rdata(i_rdata_b), .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b),
        .d_rdata(d_rdata_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .fetch_boost(boost_b));

    mem_port_arbiter #(.MEM_LAT(2)) u_c (
        .CLK(CLK), .RSTn(RSTn), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_c),
        .i_rvalid(i_rvalid_c), .i_rdata(i_rdata_c), .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt_c), .d_rvalid(d_rvalid_c),
        .d_rdata(d_rdata_c), .mem_en(mem_en_c), .mem_we(mem_we_c), .mem_addr(mem_addr_c),
        .mem_wdata(mem_wdata_c), .mem_rdata(mem_rdata_c), .fetch_boost(boost_c));

    // 3-cycle RAM for u_b returning addr + 0x100
    logic [10:0] ram_pipe [3];
    always_ff @(posedge CLK) begin
        ram_pipe[0] <= {mem_en_b, mem_addr_b};
        ram_pipe[1] <= ram_pipe[0];
        ram_pipe[2] <= ram_pipe[1];
    end
    assign mem_rdata_b = ram_pipe[2][10] ? 32'(ram_pipe[2][9:0]) + 32'h100 : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic idle();
        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    endtask

    initial begin
        // reset state with both requests raised
        i_req = 1; d_req = 1;
        mid();
        check("rst_gnt", {30'd0, i_gnt_a, d_gnt_a}, 32'd0);
        check("rst_mem", {30'd0, mem_en_a, mem_we_a}, 32'd0);
        check("rst_rvalid", {30'd0, i_rvalid_a, d_rvalid_a}, 32'd0);
        next_cycle(); idle(); RSTn = 1;
        next_cycle();

        // fetch only, MEM_LAT=1
        i_req = 1; i_addr = 10'h004;
        mid();
        check("f_gnt", {29'd0, i_gnt_a, d_gnt_a, mem_en_a}, 32'b101);
        check("f_addr", 32'(mem_addr_a), 32'h004);
        next_cycle(); idle(); mem_rdata_a = 32'h00500093;
        mid();
        check("f_rvalid", {30'd0, i_rvalid_a, d_rvalid_a}, 32'b10);
        check("f_rdata", i_rdata_a, 32'h00500093);
        next_cycle(); mem_rdata_a = 0;
        mid();
        check("f_done", 32'(i_rvalid_a), 32'd0);

        // starvation, MAX_WAIT=3
        next_cycle(); i_req = 1; d_req = 1;
        for (int c = 0; c < 8; c++) begin
            mid();
            check($sformatf("st_gnt%0d", c), {30'd0, i_gnt_a, d_gnt_a},
                  (c == 3 || c == 7) ? 32'b10 : 32'b01);
            check($sformatf("st_boost%0d", c), 32'(boost_a), 32'((c == 3 || c == 7) ? 1 : 0));
            next_cycle();
        end
        idle();
        next_cycle();

        // store ack
        d_req = 1; d_we = 1; d_addr = 10'h010; d_wdata = 32'hDEADBEEF;
        mid();
        check("s_mem", {29'd0, d_gnt_a, mem_en_a, mem_we_a}, 32'b111);
        check("s_wdata", mem_wdata_a, 32'hDEADBEEF);
        check("s_addr", 32'(mem_addr_a), 32'h010);
        next_cycle(); idle(); mem_rdata_a = 32'h12345678;
        mid();
        check("s_ack", {30'd0, i_rvalid_a, d_rvalid_a}, 32'b01);
        check("s_rdata", d_rdata_a, 32'd0);
        next_cycle(); mem_rdata_a = 0;
        next_cycle();

        // MEM_LAT=3 interleave
        i_req = 1; i_addr = 10'h000;
        next_cycle(); idle(); d_req = 1; d_addr = 10'h020;
        next_cycle(); idle(); i_req = 1; i_addr = 10'h004;
        next_cycle(); idle();
        mid();
        check("il3_iv", {30'd0, i_rvalid_b, d_rvalid_b}, 32'b10);
        check("il3_id", i_rdata_b, 32'h100);
        next_cycle();
        mid();
        check("il4_dv", {30'd0, i_rvalid_b, d_rvalid_b}, 32'b01);
        check("il4_dd", d_rdata_b, 32'h120);
        next_cycle();
        mid();
        check("il5_iv", {30'd0, i_rvalid_b, d_rvalid_b}, 32'b10);
        check("il5_id", i_rdata_b, 32'h104);
        next_cycle(); next_cycle(); next_cycle();

        // reset mid-flight, MEM_LAT=2
        d_req = 1; d_addr = 10'h030;
        mid();
        check("rm_gnt", 32'(d_gnt_c), 32'd1);
        next_cycle(); idle(); i_req = 1; RSTn = 0;
        mid();
        check("rm_forced", {29'd0, i_gnt_c, d_gnt_c, mem_en_c}, 32'd0);
        next_cycle(); RSTn = 1; i_addr = 10'h008;
        mid();
        check("rm_c2", {29'd0, d_rvalid_c, boost_c, i_gnt_c}, 32'b001);
        next_cycle(); idle();
        mid();
        check("rm_c3", {30'd0, d_rvalid_c, i_rvalid_c}, 32'd0);
        next_cycle();
        mid();
        check("rm_c4", {30'd0, d_rvalid_c, i_rvalid_c}, 32'b01);
        next_cycle();

        // idle
        mem_rdata_a = 32'h55;
        for (int c = 0; c < 10; c++) begin
            mid();
            check($sformatf("idle_ctl%0d", c),
                  {25'd0, i_gnt_a, d_gnt_a, mem_en_a, mem_we_a, i_rvalid_a, d_rvalid_a, boost_a}, 32'd0);
            check($sformatf("idle_bus%0d", c), 32'(mem_addr_a) | mem_wdata_a | i_rdata_a | d_rdata_a, 32'd0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
